// File: rtl/ex_alu_rs.sv
// ALU reservation station: buffers decoded ALU ops, snoops the result bus for
// pending operands, and issues the lowest-index ready entry into registered outputs.
module ex_alu_rs #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4,
    parameter int OP_W  = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     alloc_valid,
    output logic                     alloc_ready,
    input  logic [OP_W-1:0]          alloc_op,
    input  logic [TAG_W-1:0]         alloc_tagx,
    input  logic [TAG_W-1:0]         alloc_tagy,
    input  logic [31:0]              alloc_datax,
    input  logic [31:0]              alloc_datay,
    input  logic [TAG_W-1:0]         alloc_tagw,
    input  logic [4:0]               alloc_target,
    input  logic                     cdb_valid,
    input  logic [TAG_W-1:0]         cdb_tag,
    input  logic [31:0]              cdb_data,
    output logic                     issue_valid,
    output logic [OP_W-1:0]          issue_op,
    output logic [TAG_W-1:0]         issue_tagx,
    output logic [TAG_W-1:0]         issue_tagy,
    output logic [TAG_W-1:0]         issue_tagw,
    output logic [31:0]              issue_datax,
    output logic [31:0]              issue_datay,
    output logic [4:0]               issue_target,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    typedef struct packed {
        logic             valid;
        logic [OP_W-1:0]  op;
        logic [TAG_W-1:0] tagx;
        logic [TAG_W-1:0] tagy;
        logic [TAG_W-1:0] tagw;
        logic [31:0]      datax;
        logic [31:0]      datay;
        logic [4:0]       target;
    } entry_t;

    entry_t           ent [DEPTH];
    entry_t           new_ent;
    logic             issue_any;
    logic [IDX_W-1:0] issue_idx;
    logic [IDX_W-1:0] free_idx;
    logic             alloc_fire;
    logic             issue_fire;
    logic             byp_x;
    logic             byp_y;

    // Descending scan so the lowest index wins both selections.
    always_comb begin
        issue_any = 1'b0;
        issue_idx = '0;
        free_idx  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ent[i].valid && ent[i].tagx == '0 && ent[i].tagy == '0) begin
                issue_any = 1'b1;
                issue_idx = IDX_W'(i);
            end
            if (!ent[i].valid) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    assign alloc_ready = (count < CNT_W'(DEPTH));
    assign alloc_fire  = alloc_valid && alloc_ready && !flush;
    assign issue_fire  = issue_any && !flush;

    // An operand broadcast in the allocation cycle is captured on the way in.
    assign byp_x = cdb_valid && (alloc_tagx != '0) && (cdb_tag == alloc_tagx);
    assign byp_y = cdb_valid && (alloc_tagy != '0) && (cdb_tag == alloc_tagy);

    always_comb begin
        new_ent        = '0;
        new_ent.valid  = 1'b1;
        new_ent.op     = alloc_op;
        new_ent.tagw   = alloc_tagw;
        new_ent.target = alloc_target;
        new_ent.tagx   = byp_x ? '0 : alloc_tagx;
        new_ent.datax  = byp_x ? cdb_data : alloc_datax;
        new_ent.tagy   = byp_y ? '0 : alloc_tagy;
        new_ent.datay  = byp_y ? cdb_data : alloc_datay;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent[i] <= '0;
            end
            count        <= '0;
            issue_valid  <= 1'b0;
            issue_op     <= '0;
            issue_tagx   <= '0;
            issue_tagy   <= '0;
            issue_tagw   <= '0;
            issue_datax  <= '0;
            issue_datay  <= '0;
            issue_target <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent[i].valid <= 1'b0;
            end
            count       <= '0;
            issue_valid <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (cdb_valid && ent[i].valid && ent[i].tagx == cdb_tag) begin
                    ent[i].tagx  <= '0;
                    ent[i].datax <= cdb_data;
                end
                if (cdb_valid && ent[i].valid && ent[i].tagy == cdb_tag) begin
                    ent[i].tagy  <= '0;
                    ent[i].datay <= cdb_data;
                end
                if (issue_fire && issue_idx == IDX_W'(i)) begin
                    ent[i].valid <= 1'b0;
                end
                // The free slot is never the issuing slot, so these never collide.
                if (alloc_fire && free_idx == IDX_W'(i)) begin
                    ent[i] <= new_ent;
                end
            end
            count       <= count + {{IDX_W{1'b0}}, alloc_fire} - {{IDX_W{1'b0}}, issue_fire};
            issue_valid <= issue_fire;
            if (issue_fire) begin
                issue_op     <= ent[issue_idx].op;
                issue_tagx   <= ent[issue_idx].tagx;
                issue_tagy   <= ent[issue_idx].tagy;
                issue_tagw   <= ent[issue_idx].tagw;
                issue_datax  <= ent[issue_idx].datax;
                issue_datay  <= ent[issue_idx].datay;
                issue_target <= ent[issue_idx].target;
            end
        end
    end

endmodule

// File: doc/ex_alu_rs.md
# ex_alu_rs

ALU reservation station. It sits directly upstream of the ALU execute stage. It buffers up to DEPTH decoded ALU operations whose source operands may still be pending. It snoops the result broadcast bus to capture operands as they are produced, and issues one fully-ready operation per cycle into registered outputs that drive the ALU inputs.

## Interface
- DEPTH, 4: number of entries, power of two, 2..8
- TAG_W, 4: register tag width; tag value 0 is `UNLOCKED` (operand value present)
- OP_W, 6: ALU opcode width
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- flush  in  1  discard all entries and pending issue (mispredict)
- alloc_valid  in  1  decoder presents an ALU op
- alloc_ready  out  1  at least one free entry
- alloc_op  in  OP_W  opcode
- alloc_tagx / alloc_tagy  in  TAG_W  source tags; 0 = data valid
- alloc_datax / alloc_datay  in  32  source data, meaningful when the matching tag is 0
- alloc_tagw  in  TAG_W  destination tag, carried through unchanged
- alloc_target  in  5  destination register address
- cdb_valid  in  1  result broadcast valid
- cdb_tag  in  TAG_W  tag of the broadcast result; never 0 when cdb_valid
- cdb_data  in  32  broadcast result
- issue_valid  out  1  drives ALU busy input
- issue_op  out  OP_W
- issue_tagx / issue_tagy  out  TAG_W  always 0 when issue_valid
- issue_tagw  out  TAG_W
- issue_datax / issue_datay  out  32
- issue_target  out  5
- count  out  $clog2(DEPTH)+1  number of occupied entries

## Operation
- Entry state: valid, op, tagx, tagy, datax, datay, tagw, target.
- An entry is ready when it is valid, tagx is 0 and tagy is 0.
- **Allocation.** Fires when alloc_valid && alloc_ready && !flush. The op is written into the lowest-index invalid entry.
- **Allocation bypass.** If cdb_valid and cdb_tag equals a nonzero alloc_tagx in the same cycle, the stored tagx is 0 and the stored datax is cdb_data. The same rule applies independently to y.
- **Wakeup.** Every cycle with cdb_valid, each valid entry whose tagx equals cdb_tag loads datax from cdb_data and clears tagx to 0. The same rule applies to y. Both operands of one entry may wake on the same broadcast.
- **Issue.** Each cycle, the lowest-index ready entry, based on pre-edge state, is selected.
  - At the edge, its fields load into the issue registers, issue_valid becomes 1, and the entry is invalidated.
  - If no entry is ready, issue_valid becomes 0 and the other issue registers hold their values.
- The ALU is combinational and always accepts, so there is no back-pressure on issue.
- An entry that wakes this cycle is not issue-eligible until the next cycle. There is no wakeup-to-issue bypass.
- **Full/empty.** alloc_ready = (count < DEPTH), computed from registered state.
  - An entry freed by issue in a cycle is not reusable for allocation in that same cycle.
  - alloc_valid while alloc_ready is 0 is ignored; the decoder holds the op.
- **count.** count' = count + alloc_fire − issue_fire.
- **Flush.** Takes priority over everything else. At the edge, all entries are invalidated, count becomes 0 and issue_valid becomes 0. Allocation, wakeup and issue are suppressed in that cycle.
- **Reset.** While rst_n is low at an edge: all entries are invalid, count = 0, issue_valid = 0, and every issue data, tag, op and target register is 0. Reset mid-operation discards everything, exactly like flush.
- Tags are compared as full TAG_W-bit equality. Data is not altered.

## Timing
- Allocation at edge N makes the entry visible in cycle N+1.
- An allocation with both operands ready, in an otherwise empty station, drives issue_valid=1 after edge N+1. Allocation-to-ALU latency is 2 edges.
- A CDB broadcast at edge M clears the tag. The earliest issue is at edge M+1.
- Sustained throughput is one issue per cycle. Allocation and issue may occur in the same cycle.
- alloc_ready and count are pure register outputs. There is no combinational path from alloc_valid or cdb_* to any output.

## Test plan
- **Reset and basic issue.** Hold rst_n=0 for 2 cycles, then release. Allocate op=ADD, tagx=tagy=0, datax=5, datay=7, tagw=3, target=9. Required:
  - all outputs are 0 after reset;
  - issue_valid=1 with datax=5, datay=7, tagw=3, target=9 exactly 2 edges after allocation;
  - count returns to 0.
- **Wakeup.** Allocate tagx=4 and tagy=0 with datay=2. Broadcast cdb tag=4, data=0x10 three cycles later. Required:
  - no issue before the broadcast;
  - issue one edge after the broadcast edge, with datax=0x10.
- **Allocation bypass.** Allocate tagx=6 while cdb_valid carries tag=6, data=0xAB in the same cycle. Required: the entry is ready immediately and issues with datax=0xAB.
- **Full.** Allocate 4 entries, all with tagx=5. Required:
  - alloc_ready=0 and count=4;
  - a 5th alloc_valid is ignored;
  - broadcasting tag=5 makes the entries issue in index order 0,1,2,3 on consecutive cycles;
  - alloc_ready returns to 1 one edge after the first issue.
- **Out-of-order readiness.** Entry0 waits on tag=2 and entry1 is ready. Required: entry1 issues first. After tag=2 is broadcast, entry0 issues.
- **Flush with simultaneous events.** With 3 entries valid, assert flush in the same cycle as alloc_valid and cdb_valid. Required:
  - count=0 and issue_valid=0 at the next edge;
  - the allocated op is not stored;
  - no later issue occurs.
